mul_request_sequencer: RTL

- Upstream issue stage for the configurable 16x16 multiplier.
- Accepts multiply requests over a valid/ready handshake and registers the operands, mode and tag.
- Drives the multiplier's enable, mode and operand inputs, and holds them stable until the multiplier's data-valid is seen.
- Returns the captured product with its tag over a valid/ready response handshake, and flags illegal modes and timeouts.

---
 rtl/mul_request_sequencer_pkg.sv | 20 ++
 rtl/mul_request_sequencer_counter.sv | 45 ++++
 rtl/mul_request_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mul_request_sequencer_pkg.sv
// rtl/mul_request_sequencer_pkg.sv - shared modes, error codes and state encoding for the multiplier issue stage
package mul_request_sequencer_pkg;

    localparam logic [1:0] CM_8X8     = 2'b00;
    localparam logic [1:0] CM_DUAL8   = 2'b01;
    localparam logic [1:0] CM_16X16   = 2'b10;
    localparam logic [1:0] CM_ILLEGAL = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_MODE    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/mul_request_sequencer_counter.sv
// rtl/mul_request_sequencer_counter.sv - RUN cycle counter with timeout compare and 8-bit saturated report
module sat_cycle_counter #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clear_i,
    input  logic       inc_i,
    output logic       first_o,
    output logic       timeout_o,
    output logic [7:0] cycles_o
);

    // Wide enough to reach the timeout even when it exceeds the 8-bit report range.
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W + 1)'(TIMEOUT_CYCLES);
    localparam logic [CNT_W:0] SAT_VAL     = (CNT_W + 1)'(255);
    localparam logic [CNT_W:0] ONE         = (CNT_W + 1)'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_next;

    always_comb begin
        cnt_next = {1'b0, cnt_q} + ONE;
        cnt_d    = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_next[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign first_o   = (cnt_q == '0);
    assign timeout_o = (cnt_next == TIMEOUT_VAL);
    assign cycles_o  = (cnt_next > SAT_VAL) ? 8'hFF : cnt_next[7:0];

endmodule

// File: rtl/mul_request_sequencer.sv
// rtl/mul_request_sequencer.sv - issues one request at a time to the 16x16 multiplier and returns its tagged result
module mul_request_sequencer
    import mul_request_sequencer_pkg::*;
#(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_mode_i,
    input  logic [15:0]      req_a_i,
    input  logic [15:0]      req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             mul_enable_o,
    output logic [1:0]       mul_cm_o,
    output logic [15:0]      mul_a_o,
    output logic [15:0]      mul_b_o,
    input  logic [31:0]      mul_product_i,
    input  logic             mul_data_valid_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_product_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic [1:0]       resp_err_o,
    output logic [7:0]       resp_cycles_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic             mul_enable_q, mul_enable_d;
    logic [1:0]       mul_cm_q, mul_cm_d;
    logic [15:0]      mul_a_q, mul_a_d;
    logic [15:0]      mul_b_q, mul_b_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_product_q, resp_product_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
    logic [1:0]       resp_err_q, resp_err_d;
    logic [7:0]       resp_cycles_q, resp_cycles_d;

    logic       cnt_clear, cnt_inc;
    logic       cnt_first, cnt_timeout;
    logic [7:0] cnt_cycles;

    sat_cycle_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_counter (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (cnt_clear),
        .inc_i     (cnt_inc),
        .first_o   (cnt_first),
        .timeout_o (cnt_timeout),
        .cycles_o  (cnt_cycles)
    );

    // A lingering data-valid from the previous operation blocks new issue.
    assign req_ready_o = (state_q == ST_IDLE) && !mul_data_valid_i;
    assign busy_o      = (state_q != ST_IDLE);

    always_comb begin
        state_d        = state_q;
        mul_enable_d   = mul_enable_q;
        mul_cm_d       = mul_cm_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        resp_valid_d   = resp_valid_q;
        resp_product_d = resp_product_q;
        resp_tag_d     = resp_tag_q;
        resp_err_d     = resp_err_q;
        resp_cycles_d  = resp_cycles_q;
        cnt_clear      = 1'b0;
        cnt_inc        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    resp_tag_d = req_tag_i;
                    if (req_mode_i == CM_ILLEGAL) begin
                        resp_product_d = '0;
                        resp_err_d     = ERR_MODE;
                        resp_cycles_d  = '0;
                        resp_valid_d   = 1'b1;
                        state_d        = ST_RESP;
                    end else begin
                        mul_a_d      = req_a_i;
                        mul_b_d      = req_b_i;
                        mul_cm_d     = req_mode_i;
                        mul_enable_d = 1'b1;
                        cnt_clear    = 1'b1;
                        state_d      = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_inc = 1'b1;
                // The first RUN cycle may still see the previous result's valid.
                if (!cnt_first && mul_data_valid_i) begin
                    resp_product_d = mul_product_i;
                    resp_err_d     = ERR_NONE;
                    resp_cycles_d  = cnt_cycles;
                    resp_valid_d   = 1'b1;
                    mul_enable_d   = 1'b0;
                    state_d        = ST_RESP;
                end else if (cnt_timeout) begin
                    resp_product_d = '0;
                    resp_err_d     = ERR_TIMEOUT;
                    resp_cycles_d  = cnt_cycles;
                    resp_valid_d   = 1'b1;
                    mul_enable_d   = 1'b0;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = mul_data_valid_i ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                mul_enable_d = 1'b0;
                if (!mul_data_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            mul_enable_q   <= 1'b0;
            mul_cm_q       <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_product_q <= '0;
            resp_tag_q     <= '0;
            resp_err_q     <= '0;
            resp_cycles_q  <= '0;
        end else begin
            state_q        <= state_d;
            mul_enable_q   <= mul_enable_d;
            mul_cm_q       <= mul_cm_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            resp_valid_q   <= resp_valid_d;
            resp_product_q <= resp_product_d;
            resp_tag_q     <= resp_tag_d;
            resp_err_q     <= resp_err_d;
            resp_cycles_q  <= resp_cycles_d;
        end
    end

    assign mul_enable_o   = mul_enable_q;
    assign mul_cm_o       = mul_cm_q;
    assign mul_a_o        = mul_a_q;
    assign mul_b_o        = mul_b_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_product_o = resp_product_q;
    assign resp_tag_o     = resp_tag_q;
    assign resp_err_o     = resp_err_q;
    assign resp_cycles_o  = resp_cycles_q;

endmodule
